// File: rtl/yazmac_obegi_pkg.sv
// Shared widths and types for the COZ integer register file.
package yazmac_obegi_pkg;

  localparam int unsigned YAZMAC_ADRES_BIT = 5;
  localparam int unsigned VERI_BIT         = 32;

  typedef logic [YAZMAC_ADRES_BIT-1:0] adres_t;
  typedef logic [VERI_BIT-1:0]         veri_t;

  localparam adres_t X0_ADRES = '0;

endpackage

// File: rtl/yazmac_obegi_if.sv
// Writeback bus plus decoder read/reserve port of the register file.
interface yazmac_obegi_if;
  import yazmac_obegi_pkg::*;

  adres_t cyo_yaz_adres_i;
  veri_t  cyo_yaz_deger_i;
  logic   cyo_yaz_yazmac_i;
  adres_t coz_rs1_adres_i;
  adres_t coz_rs2_adres_i;
  veri_t  coz_rs1_deger_o;
  veri_t  coz_rs2_deger_o;
  logic   coz_rs1_hazir_o;
  logic   coz_rs2_hazir_o;
  logic   coz_rd_ayir_i;
  adres_t coz_rd_adres_i;
  logic   coz_ayir_dolu_o;

  modport master (
    output cyo_yaz_adres_i, cyo_yaz_deger_i, cyo_yaz_yazmac_i,
    output coz_rs1_adres_i, coz_rs2_adres_i, coz_rd_ayir_i, coz_rd_adres_i,
    input  coz_rs1_deger_o, coz_rs2_deger_o, coz_rs1_hazir_o, coz_rs2_hazir_o,
    input  coz_ayir_dolu_o
  );

  modport slave (
    input  cyo_yaz_adres_i, cyo_yaz_deger_i, cyo_yaz_yazmac_i,
    input  coz_rs1_adres_i, coz_rs2_adres_i, coz_rd_ayir_i, coz_rd_adres_i,
    output coz_rs1_deger_o, coz_rs2_deger_o, coz_rs1_hazir_o, coz_rs2_hazir_o,
    output coz_ayir_dolu_o
  );

endinterface

// File: rtl/yazmac_puan_tablosu.sv
// Per-register pending-write counters with hazir/dolu outputs.
// YAZMAC_ATLATMA_EN: a counter of 1 being released this cycle already counts as ready.
module yazmac_puan_tablosu
  import yazmac_obegi_pkg::*;
#(
  parameter int unsigned YAZMAC_SAYISI = 32,
  parameter int unsigned BEKLEYEN_BIT  = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   yaz_en_i,
  input  adres_t yaz_adres_i,
  input  logic   ayir_i,
  input  adres_t rd_adres_i,
  input  adres_t rs1_adres_i,
  input  adres_t rs2_adres_i,
  output logic   rs1_hazir_o,
  output logic   rs2_hazir_o,
  output logic   dolu_o
);

  typedef logic [BEKLEYEN_BIT-1:0] sayac_t;
  localparam sayac_t DOLU = '1;
  localparam sayac_t BIR  = sayac_t'(1);

  sayac_t sayac_q [YAZMAC_SAYISI];
  sayac_t sayac_d [YAZMAC_SAYISI];

  always_comb begin
    logic ayir, birak;
    ayir  = 1'b0;
    birak = 1'b0;
    for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) begin
      sayac_d[i] = sayac_q[i];
    end
    // Entry 0 is never touched, so x0 always reads ready.
    for (int unsigned i = 1; i < YAZMAC_SAYISI; i++) begin
      ayir  = ayir_i && (rd_adres_i == adres_t'(i)) && (sayac_q[i] != DOLU);
      birak = yaz_en_i && (yaz_adres_i == adres_t'(i)) && (sayac_q[i] != '0);
      if (ayir && !birak) begin
        sayac_d[i] = sayac_q[i] + BIR;
      end else if (birak && !ayir) begin
        sayac_d[i] = sayac_q[i] - BIR;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) begin
        sayac_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) begin
        sayac_q[i] <= sayac_d[i];
      end
    end
  end

  always_comb begin
    rs1_hazir_o = (rs1_adres_i == X0_ADRES) || (sayac_q[rs1_adres_i] == '0);
    rs2_hazir_o = (rs2_adres_i == X0_ADRES) || (sayac_q[rs2_adres_i] == '0);
`ifdef YAZMAC_ATLATMA_EN
    if (yaz_en_i && (yaz_adres_i != X0_ADRES)) begin
      if ((rs1_adres_i == yaz_adres_i) && (sayac_q[rs1_adres_i] == BIR)) rs1_hazir_o = 1'b1;
      if ((rs2_adres_i == yaz_adres_i) && (sayac_q[rs2_adres_i] == BIR)) rs2_hazir_o = 1'b1;
    end
`endif
    dolu_o = (sayac_q[rd_adres_i] == DOLU);
  end

endmodule

// File: rtl/yazmac_obegi.sv
// COZ integer register file: one writeback port, two async read ports, RAW scoreboard.
// YAZMAC_ATLATMA_EN: forward a same-cycle writeback to the read ports.
module yazmac_obegi
  import yazmac_obegi_pkg::*;
#(
  parameter int unsigned YAZMAC_SAYISI = 32,
  parameter int unsigned BEKLEYEN_BIT  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  yazmac_obegi_if.slave   bus
);

  veri_t yazmac_q [YAZMAC_SAYISI];
  logic  yaz_gecerli;

  assign yaz_gecerli = bus.cyo_yaz_yazmac_i && (bus.cyo_yaz_adres_i != X0_ADRES);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) begin
        yazmac_q[i] <= '0;
      end
    end else if (yaz_gecerli) begin
      yazmac_q[bus.cyo_yaz_adres_i] <= bus.cyo_yaz_deger_i;
    end
  end

  always_comb begin
    bus.coz_rs1_deger_o = yazmac_q[bus.coz_rs1_adres_i];
    bus.coz_rs2_deger_o = yazmac_q[bus.coz_rs2_adres_i];
`ifdef YAZMAC_ATLATMA_EN
    if (yaz_gecerli && (bus.coz_rs1_adres_i == bus.cyo_yaz_adres_i)) begin
      bus.coz_rs1_deger_o = bus.cyo_yaz_deger_i;
    end
    if (yaz_gecerli && (bus.coz_rs2_adres_i == bus.cyo_yaz_adres_i)) begin
      bus.coz_rs2_deger_o = bus.cyo_yaz_deger_i;
    end
`endif
    if (bus.coz_rs1_adres_i == X0_ADRES) bus.coz_rs1_deger_o = '0;
    if (bus.coz_rs2_adres_i == X0_ADRES) bus.coz_rs2_deger_o = '0;
  end

  yazmac_puan_tablosu #(
    .YAZMAC_SAYISI (YAZMAC_SAYISI),
    .BEKLEYEN_BIT  (BEKLEYEN_BIT)
  ) u_puan_tablosu (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .yaz_en_i    (bus.cyo_yaz_yazmac_i),
    .yaz_adres_i (bus.cyo_yaz_adres_i),
    .ayir_i      (bus.coz_rd_ayir_i),
    .rd_adres_i  (bus.coz_rd_adres_i),
    .rs1_adres_i (bus.coz_rs1_adres_i),
    .rs2_adres_i (bus.coz_rs2_adres_i),
    .rs1_hazir_o (bus.coz_rs1_hazir_o),
    .rs2_hazir_o (bus.coz_rs2_hazir_o),
    .dolu_o      (bus.coz_ayir_dolu_o)
  );

endmodule

// File: tb/tb_yazmac_obegi.sv
// Directed vector bench for yazmac_obegi; expectations follow YAZMAC_ATLATMA_EN.
module tb_yazmac_obegi;

`ifdef YAZMAC_ATLATMA_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  yazmac_obegi_if bus ();

  yazmac_obegi #(
    .YAZMAC_SAYISI (32),
    .BEKLEYEN_BIT  (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        yaz;
    logic [4:0]  ya;
    logic [31:0] yd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ayir;
    logic [4:0]  rd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eh1;
    logic        eh2;
    logic        edolu;
  } vec_t;

  localparam int NV = 21;
  vec_t v [NV];

  function automatic vec_t mk(logic yaz, logic [4:0] ya, logic [31:0] yd, logic [4:0] r1,
                              logic [4:0] r2, logic ayir, logic [4:0] rd, logic [31:0] e1,
                              logic [31:0] e2, logic eh1, logic eh2, logic edolu);
    vec_t t;
    t.yaz = yaz; t.ya = ya; t.yd = yd; t.r1 = r1; t.r2 = r2; t.ayir = ayir; t.rd = rd;
    t.e1 = e1; t.e2 = e2; t.eh1 = eh1; t.eh2 = eh2; t.edolu = edolu;
    return t;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(logic yaz, logic [4:0] ya, logic [31:0] yd, logic [4:0] r1,
                       logic [4:0] r2, logic ayir, logic [4:0] rd);
    bus.cyo_yaz_yazmac_i = yaz;
    bus.cyo_yaz_adres_i  = ya;
    bus.cyo_yaz_deger_i  = yd;
    bus.coz_rs1_adres_i  = r1;
    bus.coz_rs2_adres_i  = r2;
    bus.coz_rd_ayir_i    = ayir;
    bus.coz_rd_adres_i   = rd;
  endtask

  initial begin
    // Rows: inputs for one cycle, outputs expected before that cycle's rising edge.
    v[0]  = mk(0, 0, 0,            5, 0, 0, 0, 0, 0, 1, 1, 0);
    v[1]  = mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 1, 1, 0);
    v[2]  = mk(1, 0, 32'h1234,     5, 0, 0, 0, 32'hDEADBEEF, 0, 1, 1, 0);
    v[3]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 1, 1, 0);
    v[4]  = mk(1, 7, 32'hA5A5A5A5, 5, 7, 0, 0, 32'hDEADBEEF, BYP ? 32'hA5A5A5A5 : 32'h0,
               1, 1, 0);
    v[5]  = mk(0, 0, 0,            5, 7, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 1, 1, 0);
    v[6]  = mk(0, 0, 0,            3, 0, 1, 3, 0, 0, 1, 1, 0);
    v[7]  = mk(0, 0, 0,            3, 0, 0, 3, 0, 0, 0, 1, 0);
    v[8]  = mk(1, 3, 32'h11,       3, 0, 0, 3, BYP ? 32'h11 : 32'h0, 0, BYP, 1, 0);
    v[9]  = mk(0, 0, 0,            3, 0, 0, 3, 32'h11, 0, 1, 1, 0);
    v[10] = mk(0, 0, 0,            9, 0, 1, 9, 0, 0, 1, 1, 0);
    v[11] = mk(0, 0, 0,            9, 0, 1, 9, 0, 0, 0, 1, 0);
    v[12] = mk(0, 0, 0,            9, 0, 1, 9, 0, 0, 0, 1, 0);
    v[13] = mk(0, 0, 0,            9, 0, 1, 9, 0, 0, 0, 1, 1);
    v[14] = mk(1, 9, 32'h1,        9, 0, 0, 9, BYP ? 32'h1 : 32'h0, 0, 0, 1, 1);
    v[15] = mk(1, 9, 32'h2,        9, 0, 0, 9, BYP ? 32'h2 : 32'h1, 0, 0, 1, 0);
    v[16] = mk(1, 9, 32'h3,        9, 0, 0, 9, BYP ? 32'h3 : 32'h2, 0, BYP, 1, 0);
    v[17] = mk(0, 0, 0,            9, 0, 0, 9, 32'h3, 0, 1, 1, 0);
    v[18] = mk(0, 0, 0,            9, 4, 1, 4, 32'h3, 0, 1, 1, 0);
    v[19] = mk(1, 4, 32'h44,       9, 4, 1, 4, 32'h3, BYP ? 32'h44 : 32'h0, 1, BYP, 0);
    v[20] = mk(0, 0, 0,            9, 4, 0, 4, 32'h3, 32'h44, 1, 0, 0);

    drive(0, 0, 0, 5, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rs1_deger", -1, bus.coz_rs1_deger_o, 32'h0);
    chk("reset_rs1_hazir", -1, {31'b0, bus.coz_rs1_hazir_o}, 32'h1);
    chk("reset_dolu", -1, {31'b0, bus.coz_ayir_dolu_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(v[i].yaz, v[i].ya, v[i].yd, v[i].r1, v[i].r2, v[i].ayir, v[i].rd);
      @(negedge clk);
      chk("rs1_deger", i, bus.coz_rs1_deger_o, v[i].e1);
      chk("rs2_deger", i, bus.coz_rs2_deger_o, v[i].e2);
      chk("rs1_hazir", i, {31'b0, bus.coz_rs1_hazir_o}, {31'b0, v[i].eh1});
      chk("rs2_hazir", i, {31'b0, bus.coz_rs2_hazir_o}, {31'b0, v[i].eh2});
      chk("ayir_dolu", i, {31'b0, bus.coz_ayir_dolu_o}, {31'b0, v[i].edolu});
    end

    // Load x9 to full and x4 pending, then reset between edges.
    @(posedge clk);
    #1;
    drive(0, 0, 0, 9, 4, 1, 9);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 0, 0, 9, 4, 0, 9);
    @(negedge clk);
    chk("pre_reset_dolu", 100, {31'b0, bus.coz_ayir_dolu_o}, 32'h1);
    chk("pre_reset_rs2_hazir", 100, {31'b0, bus.coz_rs2_hazir_o}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rs1_deger", 101, bus.coz_rs1_deger_o, 32'h0);
    chk("async_rst_rs1_hazir", 101, {31'b0, bus.coz_rs1_hazir_o}, 32'h1);
    chk("async_rst_rs2_hazir", 101, {31'b0, bus.coz_rs2_hazir_o}, 32'h1);
    chk("async_rst_dolu", 101, {31'b0, bus.coz_ayir_dolu_o}, 32'h0);
    drive(0, 0, 0, 5, 7, 0, 0);
    #1;
    chk("async_rst_x5", 102, bus.coz_rs1_deger_o, 32'h0);
    chk("async_rst_x7", 102, bus.coz_rs2_deger_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Release at counter 0 still writes the value.
    @(posedge clk);
    #1;
    drive(1, 12, 32'hCAFE0001, 12, 12, 0, 12);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 12, 12, 0, 12);
    @(negedge clk);
    chk("release_at_zero_deger", 103, bus.coz_rs1_deger_o, 32'hCAFE0001);
    chk("release_at_zero_hazir", 103, {31'b0, bus.coz_rs1_hazir_o}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
